// File: rtl/video_mode_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : video_mode_sequencer
//  Purpose  : Frame-synchronous controller for the video pipeline mode bits.
//             Configuration writes are held as a pending set and are applied
//             only at a VSync leading edge, so a mode never changes in the
//             middle of a frame. A change to any sync-retiming ("hard") field
//             also blanks the picture for MUTE_FRAMES frames while the
//             monitor resynchronises. If VSync stops, a timeout counter
//             stands in for the missing edge.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_sys             in   master clock, rising edge
//    reset_n             in   asynchronous active-low reset
//    VSync               in   core vertical sync, active level VS_POL
//    cfg_wr              in   one-cycle strobe, samples every cfg_* input
//    cfg_scanlines[1:0]  in   requested scanline mode            (soft)
//    cfg_sd_disable      in   requested scandoubler bypass       (hard)
//    cfg_no_csync        in   requested csync disable            (hard)
//    cfg_ypbpr           in   requested YPbPr output             (hard)
//    cfg_blend           in   requested blend                    (soft)
//    cfg_rotate[1:0]     in   requested OSD rotation             (soft)
//    scanlines .. rotate out  applied mode values
//    video_mute          out  1 = downstream forces RGB to 0
//    busy                out  1 while a change is pending or mute is active
//    vs_timeout          out  one-cycle pulse when a timeout replaced VSync
// ============================================================================
module video_mode_sequencer #(
    parameter int   MUTE_FRAMES = 4,
    parameter logic VS_POL      = 1'b0,
    parameter int   TO_WIDTH    = 22
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       VSync,
    input  logic       cfg_wr,
    input  logic [1:0] cfg_scanlines,
    input  logic       cfg_sd_disable,
    input  logic       cfg_no_csync,
    input  logic       cfg_ypbpr,
    input  logic       cfg_blend,
    input  logic [1:0] cfg_rotate,
    output logic [1:0] scanlines,
    output logic       scandoubler_disable,
    output logic       no_csync,
    output logic       ypbpr,
    output logic       blend,
    output logic [1:0] rotate,
    output logic       video_mute,
    output logic       busy,
    output logic       vs_timeout
);

    // Frame counter must hold MUTE_FRAMES; keep at least one bit when muting
    // is disabled so the declaration stays legal.
    localparam int             c_fc_w       = (MUTE_FRAMES > 0) ? $clog2(MUTE_FRAMES + 1) : 1;
    localparam logic [c_fc_w-1:0] c_mute_init = c_fc_w'(MUTE_FRAMES);
    localparam logic [c_fc_w-1:0] c_fc_one    = c_fc_w'(1);
    localparam logic           c_has_mute   = (MUTE_FRAMES > 0);

    typedef enum logic [1:0] {
        c_IDLE    = 2'd0,
        c_WAIT_VS = 2'd1,
        c_MUTE    = 2'd2
    } state_t;

    // Mode set packing: [7:6] scanlines, [5] sd_disable, [4] no_csync,
    // [3] ypbpr, [2] blend, [1:0] rotate. Bits [5:3] are the hard fields.
    logic [7:0]          w_cfg_set;
    logic [7:0]          r_applied;
    logic [7:0]          r_pend_set;
    logic                r_pend;

    state_t              r_state;
    state_t              w_state_next;

    logic                r_vs_d;
    logic                w_vs_edge;
    logic [TO_WIDTH-1:0] r_to_cnt;
    logic                w_to_full;
    logic                w_tick;
    logic                w_timeout;
    logic                w_enter_wait;

    logic [c_fc_w-1:0]   r_frame_cnt;
    logic                r_mute;
    logic                r_vs_timeout;

    logic                w_hard_diff;
    logic                w_apply;
    logic                w_mute_set;
    logic                w_mute_clr;

    assign w_cfg_set = {cfg_scanlines, cfg_sd_disable, cfg_no_csync,
                        cfg_ypbpr, cfg_blend, cfg_rotate};

    // ------------------------------------------------------------------
    // Frame tick: a real VSync leading edge, or the watchdog running out.
    // ------------------------------------------------------------------
    assign w_vs_edge    = (VSync == VS_POL) && (r_vs_d != VS_POL);
    assign w_to_full    = &r_to_cnt;
    assign w_tick       = w_vs_edge | w_to_full;
    assign w_timeout    = w_to_full & ~w_vs_edge & (r_state != c_IDLE);
    assign w_enter_wait = (r_state == c_IDLE) && r_pend;

    assign w_hard_diff  = (r_pend_set[5:3] != r_applied[5:3]);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_vs_d       <= VS_POL;
            r_to_cnt     <= '0;
            r_vs_timeout <= 1'b0;
        end else begin
            r_vs_d       <= VSync;
            r_vs_timeout <= w_timeout;
            // All-ones wraps to zero by the increment itself, which is what
            // restarts the count after a timeout-driven tick.
            if (w_vs_edge || w_enter_wait) begin
                r_to_cnt <= '0;
            end else if (r_state != c_IDLE) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_apply      = 1'b0;
        w_mute_set   = 1'b0;
        w_mute_clr   = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (r_pend) begin
                    w_state_next = c_WAIT_VS;
                end
            end
            c_WAIT_VS: begin
                if (w_tick) begin
                    w_apply = 1'b1;
                    if (c_has_mute && w_hard_diff) begin
                        w_mute_set   = 1'b1;
                        w_state_next = c_MUTE;
                    end else begin
                        w_state_next = c_IDLE;
                    end
                end
            end
            c_MUTE: begin
                if (w_tick && (r_frame_cnt == c_fc_one)) begin
                    w_mute_clr   = 1'b1;
                    w_state_next = c_IDLE;
                end
            end
            default: begin
                w_state_next = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pending / applied sets, mute frame counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_pend_set  <= '0;
            r_pend      <= 1'b0;
            r_applied   <= '0;
            r_frame_cnt <= '0;
            r_mute      <= 1'b0;
        end else begin
            // A write landing on the apply tick wins over the clear, so the
            // newer request survives and is handled on the next pass.
            if (cfg_wr) begin
                r_pend_set <= w_cfg_set;
                r_pend     <= !((r_state == c_IDLE) && (w_cfg_set == r_applied));
            end else if (w_apply) begin
                r_pend     <= 1'b0;
            end

            if (w_apply) begin
                r_applied <= r_pend_set;
            end

            if (w_mute_set) begin
                r_frame_cnt <= c_mute_init;
            end else if ((r_state == c_MUTE) && w_tick) begin
                r_frame_cnt <= r_frame_cnt - 1'b1;
            end

            if (w_mute_set) begin
                r_mute <= 1'b1;
            end else if (w_mute_clr) begin
                r_mute <= 1'b0;
            end
        end
    end

    assign scanlines           = r_applied[7:6];
    assign scandoubler_disable = r_applied[5];
    assign no_csync            = r_applied[4];
    assign ypbpr               = r_applied[3];
    assign blend               = r_applied[2];
    assign rotate              = r_applied[1:0];
    assign video_mute          = r_mute;
    assign busy                = (r_state != c_IDLE) | r_pend;
    assign vs_timeout          = r_vs_timeout;

endmodule
`default_nettype wire
